// File: rtl/bram_arbiter_if.sv
// -----------------------------------------------------------------------------
// bram_arbiter_if
// Bundles the two requester handshakes and the shared-BRAM request side of
// bram_arbiter.
//   a_valid/b_valid   requester valid
//   a_ready/b_ready   single-cycle completion pulse
//   a_addr/b_addr     word address (WIDTH bits)
//   a_wdata/b_wdata   write data
//   a_wmask/b_wmask   byte-write mask, 0000 = read
//   a_rdata/b_rdata   read data, valid with ready
//   bram_addr/wdata/wmask  request presented to the BRAM
//   bram_rdata        BRAM registered read data
//   owner             0 = A, 1 = B, requester of the transaction in flight
// Modports: slave = arbiter view, master = environment (requesters + BRAM).
// -----------------------------------------------------------------------------
interface bram_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] a_addr;
   logic [31:0]      a_wdata;
   logic [3:0]       a_wmask;
   logic [31:0]      a_rdata;

   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] b_addr;
   logic [31:0]      b_wdata;
   logic [3:0]       b_wmask;
   logic [31:0]      b_rdata;

   logic [WIDTH-1:0] bram_addr;
   logic [31:0]      bram_wdata;
   logic [3:0]       bram_wmask;
   logic [31:0]      bram_rdata;

   logic             owner;

   modport slave (
      input  a_valid, a_addr, a_wdata, a_wmask,
      input  b_valid, b_addr, b_wdata, b_wmask,
      input  bram_rdata,
      output a_ready, a_rdata, b_ready, b_rdata,
      output bram_addr, bram_wdata, bram_wmask, owner
   );

   modport master (
      output a_valid, a_addr, a_wdata, a_wmask,
      output b_valid, b_addr, b_wdata, b_wmask,
      output bram_rdata,
      input  a_ready, a_rdata, b_ready, b_rdata,
      input  bram_addr, bram_wdata, bram_wmask, owner
   );
endinterface

// File: rtl/bram_arbiter.sv
// -----------------------------------------------------------------------------
// bram_arbiter
// Two-requester arbiter in front of a single-port BRAM with registered read
// data. Each transaction takes three cycles: IDLE (sample + capture request),
// ISSUE (request held on the BRAM pins, BRAM samples at the end), RESP (owner
// sees ready and rdata straight from the BRAM output).
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active high
//   bus    bram_arbiter_if.slave (requesters A/B, BRAM side, owner)
// Build option:
//   BRAM_ARBITER_FIXED_PRIO_EN  defined -> A always wins ties
//                               undefined -> round-robin on ties
// -----------------------------------------------------------------------------
module bram_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   bram_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_addr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wmask;
   logic             r_owner;
   logic             w_req;
   logic             w_sel_b;
   logic             w_a_ready;
   logic             w_b_ready;
   logic [31:0]      w_a_rdata;
   logic [31:0]      w_b_rdata;

   assign w_req = bus.a_valid | bus.b_valid;

`ifdef BRAM_ARBITER_FIXED_PRIO_EN
   // B only wins when A is not asking.
   assign w_sel_b = bus.b_valid & ~bus.a_valid;
`else
   // On a tie, serve whoever was not served last.
   logic r_last_b;
   assign w_sel_b = bus.b_valid & (~bus.a_valid | ~r_last_b);
`endif

   // State and captured request. Only the IDLE sample is ever registered, so
   // requester changes after that point have no effect.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
         r_owner <= 1'b0;
`ifndef BRAM_ARBITER_FIXED_PRIO_EN
         r_last_b <= 1'b1;
`endif
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_req) begin
            r_addr  <= w_sel_b ? bus.b_addr  : bus.a_addr;
            r_wdata <= w_sel_b ? bus.b_wdata : bus.a_wdata;
            r_wmask <= w_sel_b ? bus.b_wmask : bus.a_wmask;
            r_owner <= w_sel_b;
`ifndef BRAM_ARBITER_FIXED_PRIO_EN
            r_last_b <= w_sel_b;
`endif
         end
         // Write strobe lives only in ISSUE so each write lands once.
         if (r_state == ISSUE) r_wmask <= '0;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_a_ready = 1'b0;
      w_b_ready = 1'b0;
      w_a_rdata = '0;
      w_b_rdata = '0;
      case (r_state)
         IDLE:  if (w_req) w_next = ISSUE;
         ISSUE: w_next = RESP;
         RESP: begin
            w_next = IDLE;
            if (r_owner) begin
               w_b_ready = 1'b1;
               w_b_rdata = bus.bram_rdata;
            end else begin
               w_a_ready = 1'b1;
               w_a_rdata = bus.bram_rdata;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign bus.bram_addr  = r_addr;
   assign bus.bram_wdata = r_wdata;
   assign bus.bram_wmask = r_wmask;
   assign bus.owner      = r_owner;
   assign bus.a_ready    = w_a_ready;
   assign bus.b_ready    = w_b_ready;
   assign bus.a_rdata    = w_a_rdata;
   assign bus.b_rdata    = w_b_rdata;

endmodule
